// File: rtl/shift_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_arbiter_pkg
//  Description : Shared state encoding, direction constants and the
//                round-robin pick helper for the shift arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_arbiter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t EXEC = 2'd1;
    localparam state_t RESP = 2'd2;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Winner index: a lone requester wins; on a tie the one not granted last wins.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) begin
            return ~last;
        end
        return v1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_arbiter_if
//  Description : Request/response handshake bundle for both requesters of the
//                shift arbiter. master = requester side, slave = arbiter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface shift_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_dir;
    logic             resp0_valid;
    logic             resp0_ready;
    logic [WIDTH-1:0] resp0_data;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_dir;
    logic             resp1_valid;
    logic             resp1_ready;
    logic [WIDTH-1:0] resp1_data;

    modport master (
        output req0_valid, req0_a, req0_b, req0_dir, resp0_ready,
        output req1_valid, req1_a, req1_b, req1_dir, resp1_ready,
        input  req0_ready, resp0_valid, resp0_data,
        input  req1_ready, resp1_valid, resp1_data
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_dir, resp0_ready,
        input  req1_valid, req1_a, req1_b, req1_dir, resp1_ready,
        output req0_ready, resp0_valid, resp0_data,
        output req1_ready, resp1_valid, resp1_data
    );
endinterface
`default_nettype wire

// File: rtl/shifter.sv
`default_nettype none
// ============================================================================
//  Module      : shifter
//  Description : Combinational logical shifter producing both the left and the
//                right shifted result of a by b, zero fill. Amounts >= WIDTH
//                yield all zeros.
//  Revision    : 1.0 - initial release
// ============================================================================
module shifter #(
    parameter int WIDTH = 4
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    output logic      [WIDTH-1:0] left_shift_result,
    output logic      [WIDTH-1:0] right_shift_result
);
    localparam logic [WIDTH:0] C_WIDTH_EXT = (WIDTH + 1)'(WIDTH);

    logic w_oversize;

    // Oversized amounts are forced to zero explicitly rather than relying on shift semantics.
    always_comb begin
        w_oversize         = ({1'b0, b} >= C_WIDTH_EXT);
        left_shift_result  = w_oversize ? '0 : (a << b);
        right_shift_result = w_oversize ? '0 : (a >> b);
    end
endmodule
`default_nettype wire

// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shift_arbiter
//  Description : Round-robin arbiter sharing one shifter between two
//                requesters; one operation in flight, valid/ready on both
//                request and response paths.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    shift_arbiter_if.slave   bus,
    output logic             busy
);
    state_t           r_state;
    state_t           w_next_state;
    logic             r_last_grant;
    logic             r_owner;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_dir;
    logic             r_resp0_valid;
    logic             r_resp1_valid;
    logic [WIDTH-1:0] r_resp0_data;
    logic [WIDTH-1:0] r_resp1_data;

    logic             w_grant;
    logic             w_accept;
    logic             w_owner_resp_ready;
    logic [WIDTH-1:0] w_left;
    logic [WIDTH-1:0] w_right;
    logic [WIDTH-1:0] w_result;

    shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .a                  (r_a),
        .b                  (r_b),
        .left_shift_result  (w_left),
        .right_shift_result (w_right)
    );

    // Arbitration and handshake qualification; ready is suppressed while reset is asserted.
    always_comb begin
        w_grant            = rr_pick(bus.req0_valid, bus.req1_valid, r_last_grant);
        w_accept           = (r_state == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
        w_owner_resp_ready = r_owner ? bus.resp1_ready : bus.resp0_ready;
        w_result           = (r_dir == DIR_RIGHT) ? w_right : w_left;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept)           w_next_state = EXEC;
            EXEC:                            w_next_state = RESP;
            RESP:    if (w_owner_resp_ready) w_next_state = IDLE;
            default:                         w_next_state = IDLE;
        endcase
    end

    // FSM outputs: request ready strobes and the busy flag.
    always_comb begin
        bus.req0_ready = w_accept && (w_grant == 1'b0);
        bus.req1_ready = w_accept && (w_grant == 1'b1);
        busy           = (r_state != IDLE);
    end

    // Operand capture and grant history on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_dir        <= DIR_LEFT;
        end else if (w_accept) begin
            r_last_grant <= w_grant;
            r_owner      <= w_grant;
            r_a          <= w_grant ? bus.req1_a   : bus.req0_a;
            r_b          <= w_grant ? bus.req1_b   : bus.req0_b;
            r_dir        <= w_grant ? bus.req1_dir : bus.req0_dir;
        end
    end

    // Response registers: loaded in EXEC for the owner, valid dropped on its handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp0_data  <= '0;
            r_resp1_data  <= '0;
        end else if (r_state == EXEC) begin
            if (r_owner) begin
                r_resp1_valid <= 1'b1;
                r_resp1_data  <= w_result;
            end else begin
                r_resp0_valid <= 1'b1;
                r_resp0_data  <= w_result;
            end
        end else if ((r_state == RESP) && w_owner_resp_ready) begin
            if (r_owner) begin
                r_resp1_valid <= 1'b0;
            end else begin
                r_resp0_valid <= 1'b0;
            end
        end
    end

    assign bus.resp0_valid = r_resp0_valid;
    assign bus.resp1_valid = r_resp1_valid;
    assign bus.resp0_data  = r_resp0_data;
    assign bus.resp1_data  = r_resp1_data;

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_arbiter
//  Description : Directed self-checking bench for shift_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;
    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    logic busy;
    int   n_vec;
    int   n_err;

    shift_arbiter_if #(.WIDTH(WIDTH)) bus ();

    shift_arbiter #(
        .WIDTH(WIDTH)
    ) u_dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and settle 1 ns past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit idx, input logic v, input logic [3:0] a,
                         input logic [3:0] b, input logic dir);
        if (idx) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_dir = dir;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_dir = dir;
        end
    endtask

    // Full single-requester transaction with the response consumed at first chance.
    task automatic do_op(input string tag, input bit idx, input logic [3:0] a,
                         input logic [3:0] b, input logic dir, input logic [3:0] exp);
        drive(idx, 1'b1, a, b, dir);
        #1;
        check_eq({tag, "_rdy"},   idx ? bus.req1_ready : bus.req0_ready, 1);
        check_eq({tag, "_ordy"},  idx ? bus.req0_ready : bus.req1_ready, 0);
        step();
        drive(idx, 1'b0, a, b, dir);
        #1;
        check_eq({tag, "_busy"},  busy, 1);
        check_eq({tag, "_exv"},   idx ? bus.resp1_valid : bus.resp0_valid, 0);
        step();
        check_eq({tag, "_rv"},    idx ? bus.resp1_valid : bus.resp0_valid, 1);
        check_eq({tag, "_data"},  idx ? bus.resp1_data  : bus.resp0_data, exp);
        check_eq({tag, "_orv"},   idx ? bus.resp0_valid : bus.resp1_valid, 0);
        if (idx) bus.resp1_ready = 1'b1; else bus.resp0_ready = 1'b1;
        step();
        check_eq({tag, "_rvclr"}, idx ? bus.resp1_valid : bus.resp0_valid, 0);
        check_eq({tag, "_idle"},  busy, 0);
        check_eq({tag, "_hold"},  idx ? bus.resp1_data  : bus.resp0_data, exp);
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
        // Contention from reset: both requesters valid while reset is held.
        drive(1'b0, 1'b1, 4'b1001, 4'b0001, 1'b0);
        drive(1'b1, 1'b1, 4'b1001, 4'b0001, 1'b1);
        step();
        step();
        check_eq("rst_rdy0",  bus.req0_ready, 0);
        check_eq("rst_rdy1",  bus.req1_ready, 0);
        check_eq("rst_busy",  busy, 0);
        check_eq("rst_rv0",   bus.resp0_valid, 0);
        check_eq("rst_rv1",   bus.resp1_valid, 0);
        check_eq("rst_d0",    bus.resp0_data, 0);
        check_eq("rst_d1",    bus.resp1_data, 0);

        rst = 1'b0;
        bus.resp0_ready = 1'b1;
        bus.resp1_ready = 1'b1;
        #1;
        check_eq("ct_g0_rdy0", bus.req0_ready, 1);
        check_eq("ct_g0_rdy1", bus.req1_ready, 0);
        step();
        check_eq("ct_exec_rdy1", bus.req1_ready, 0);
        step();
        check_eq("ct_rv0",  bus.resp0_valid, 1);
        check_eq("ct_d0",   bus.resp0_data, 4'b0010);
        check_eq("ct_rv1a", bus.resp1_valid, 0);
        step();
        check_eq("ct_rv0clr",  bus.resp0_valid, 0);
        check_eq("ct_g1_rdy1", bus.req1_ready, 1);
        check_eq("ct_g1_rdy0", bus.req0_ready, 0);
        step();
        step();
        check_eq("ct_rv1", bus.resp1_valid, 1);
        check_eq("ct_d1",  bus.resp1_data, 4'b0100);
        step();
        check_eq("ct_g2_rdy0", bus.req0_ready, 1);
        check_eq("ct_g2_rdy1", bus.req1_ready, 0);
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
        step();
        check_eq("ct_noacc_busy", busy, 0);

        // Single-requester operations and shift boundaries.
        do_op("l0",    1'b0, 4'b1101, 4'b0010, 1'b0, 4'b0100);
        do_op("r1a",   1'b1, 4'b1101, 4'b0010, 1'b1, 4'b0011);
        do_op("r1b",   1'b1, 4'b1001, 4'b0001, 1'b1, 4'b0100);
        do_op("b4l",   1'b0, 4'b1111, 4'b0100, 1'b0, 4'b0000);
        do_op("b4r",   1'b1, 4'b1111, 4'b0100, 1'b1, 4'b0000);
        do_op("bfr",   1'b0, 4'b1011, 4'b1111, 1'b1, 4'b0000);
        do_op("b0l",   1'b0, 4'b1011, 4'b0000, 1'b0, 4'b1011);
        do_op("b0r",   1'b1, 4'b0110, 4'b0000, 1'b1, 4'b0110);
        do_op("l3",    1'b1, 4'b0001, 4'b0011, 1'b0, 4'b1000);

        // Backpressure on requester 0 with requester 1 pending.
        bus.resp1_ready = 1'b1;   // asserted while resp1_valid is low: must be ignored
        drive(1'b0, 1'b1, 4'b0110, 4'b0001, 1'b0);
        #1;
        check_eq("bp_rdy0", bus.req0_ready, 1);
        step();
        bus.resp1_ready = 1'b0;
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        drive(1'b1, 1'b1, 4'b0110, 4'b0001, 1'b1);
        #1;
        check_eq("bp_exec_rdy1", bus.req1_ready, 0);
        check_eq("bp_rv1_idle",  bus.resp1_valid, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_rv0",   bus.resp0_valid, 1);
            check_eq("bp_d0",    bus.resp0_data, 4'b1100);
            check_eq("bp_busy",  busy, 1);
            check_eq("bp_rdy1",  bus.req1_ready, 0);
            step();
        end
        bus.resp0_ready = 1'b1;
        #1;
        check_eq("bp_rel_rdy1", bus.req1_ready, 0);
        step();
        bus.resp0_ready = 1'b0;
        #1;
        check_eq("bp_rv0clr",   bus.resp0_valid, 0);
        check_eq("bp_post_rdy1", bus.req1_ready, 1);
        step();
        drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        step();
        check_eq("bp_rv1", bus.resp1_valid, 1);
        check_eq("bp_d1",  bus.resp1_data, 4'b0011);
        check_eq("bp_d0k", bus.resp0_data, 4'b1100);
        bus.resp1_ready = 1'b1;
        step();
        bus.resp1_ready = 1'b0;
        check_eq("bp_done", busy, 0);

        // Reset while the operation is in EXEC: result must be discarded.
        drive(1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0);
        step();
        drive(1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0);
        #1;
        check_eq("rx_exec_busy", busy, 1);
        rst = 1'b1;
        bus.resp0_ready = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check_eq("rx_busy", busy, 0);
        check_eq("rx_rv0",  bus.resp0_valid, 0);
        check_eq("rx_rv1",  bus.resp1_valid, 0);
        check_eq("rx_d0",   bus.resp0_data, 0);
        check_eq("rx_d1",   bus.resp1_data, 0);
        step();
        check_eq("rx_rv0b", bus.resp0_valid, 0);
        bus.resp0_ready = 1'b0;
        // Tie after reset must go to requester 0 again.
        drive(1'b0, 1'b1, 4'b0011, 4'b0001, 1'b0);
        drive(1'b1, 1'b1, 4'b0011, 4'b0001, 1'b1);
        #1;
        check_eq("rx_tie_rdy0", bus.req0_ready, 1);
        check_eq("rx_tie_rdy1", bus.req1_ready, 0);
        drive(1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0);
        do_op("rx_next", 1'b0, 4'b0011, 4'b0001, 1'b0, 4'b0110);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one combinational `shifter` instance between two requesters. Round-robin arbitration, one operation in flight at a time, valid/ready handshakes on request and response. Sits between the register-file/ALU control logic and the shifter datapath, and sequences operand capture, execution and result return.

## Interface
Parameters:
- `WIDTH`, 4: operand, amount and result width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `req0_valid`, `req1_valid`  in  1: requester i presents an operation.
- `req0_ready`, `req1_ready`  out  1: the arbiter accepts requester i this cycle.
- `req0_a`, `req1_a`  in  WIDTH: operand.
- `req0_b`, `req1_b`  in  WIDTH: shift amount, unsigned.
- `req0_dir`, `req1_dir`  in  1: 0 = left, 1 = right (logical).
- `resp0_valid`, `resp1_valid`  out  1: result available for requester i.
- `resp0_ready`, `resp1_ready`  in  1: requester i consumes its result.
- `resp0_data`, `resp1_data`  out  WIDTH: shift result.
- `busy`  out  1: an operation is in flight (state is not IDLE).

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant: only one requester valid -> that one. Both valid -> the one not granted last (`last_grant`).
  - `reqN_ready` = (state==IDLE) && grant==N. Combinational from valid; at most one ready high.
  - On accept (valid & ready): latch a, b, dir and owner; update `last_grant` to owner; go to EXEC.
- EXEC:
  - Latched operands drive the `shifter`.
  - The selected result (left or right per dir) is registered into the owner's `respN_data`.
  - `respN_valid` is set; go to RESP.
- RESP:
  - Owner's `respN_valid` held high and `respN_data` held stable until `respN_ready`. Then `respN_valid` clears and the FSM returns to IDLE.
  - `respN_data` keeps its last value after the handshake.
  - The non-owner's response outputs are untouched.
- Arithmetic: logical shift, zero fill. Amount >= WIDTH gives all zeros. Amount 0 passes the operand through.
- Requests arriving while busy are stalled (ready low) and must hold stable. They are not dropped.

## Timing
- Reset values: state IDLE, `last_grant` = 1 (requester 0 wins the first tie), `busy` 0, `req0_ready`/`req1_ready` 0 during reset, `resp0_valid`/`resp1_valid` 0, `resp0_data`/`resp1_data` 0.
- Latency: accept on cycle T -> EXEC on T+1 -> `respN_valid` high from T+2.
- If `respN_ready` is already high at T+2, the FSM is back in IDLE at T+3 and the next accept can occur at T+3. Peak throughput is one operation per 3 cycles.
- Back-to-back with both requesters continuously valid: grants alternate 0,1,0,1…
- Response backpressure: RESP holds indefinitely while `respN_ready` is low. No timeout.
- Reset mid-operation (EXEC or RESP): next cycle is IDLE with all reset values. The in-flight result is discarded and no response is issued.
- `respN_ready` asserted while `respN_valid` is low: ignored.

## Structure
- Shared package:
  - State encoding constants: IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2.
  - Direction constants: DIR_LEFT = 0, DIR_RIGHT = 1.
- Sub-module: instantiate the existing `shifter` (`a`, `b`, `left_shift_result`, `right_shift_result`) unchanged, fed by the latched operands.
- Arbitration is a small combinational block inside `shift_arbiter`. No separate module.

## Test plan
- Single request, left: req0 a=1101 b=0010 dir=0 -> `req0_ready` same cycle, `resp0_valid` 2 cycles later with `resp0_data`=0100. `resp1_valid` stays 0.
- Single request, right: req1 a=1101 b=0010 dir=1 -> `resp1_data`=0011. Then a=1001 b=0001 dir=1 -> 0100.
- Contention: both valid from reset (req0 a=1001 b=0001 dir=0, req1 a=1001 b=0001 dir=1).
  - req0 granted first; `resp0_data`=0010.
  - req1 granted next; `resp1_data`=0100.
  - Held valid, grants keep alternating.
- Boundaries: b=0100 -> result 0000 both directions. b=0000 -> result equals a.
- Backpressure: hold `resp0_ready` low 5 cycles.
  - `resp0_valid` and `resp0_data` stable, `busy` 1.
  - Pending req1 sees `req1_ready` 0 until one cycle after `resp0_ready` rises.
- Reset in EXEC: assert `rst` one cycle after accept -> no response. All outputs at reset values. The next request completes normally.
